// File: rtl/isa_io_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : isa_io_arbiter                                               |
// | Description : Two-port arbiter and cycle sequencer for the ISA I/O bus.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module isa_io_arbiter #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 10,
  parameter int HOLD_CYC   = 2,
  parameter int TMO_CYC    = 64,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic [15:0] isa_addr,
  output logic [15:0] isa_dout,
  output logic        isa_doe,
  input  logic [15:0] isa_din,
  output logic        isa_iow_n,
  output logic        isa_ior_n,
  input  logic        isa_iochrdy,
  output logic        busy,
  output logic        tmo_flag,
  input  logic        tmo_clr
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_SETUP  = 3'd1;
  localparam logic [2:0] c_ST_STROBE = 3'd2;
  localparam logic [2:0] c_ST_WAIT   = 3'd3;
  localparam logic [2:0] c_ST_HOLD   = 3'd4;
  localparam logic [2:0] c_ST_DONE   = 3'd5;

  localparam logic [CNT_W-1:0] c_SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] c_STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] c_HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] c_TMO_LD    = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  logic [2:0]       r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_grant, r_last_grant, r_write;
  logic [15:0]      r_addr, r_wdata, r_rdata, r_m0_rdata, r_m1_rdata;
  logic             r_rdy_meta, r_rdy_sync, r_tmo_flag;
  logic             w_cnt_zero, w_any_req, w_grant, w_to_hold, w_tmo_hit;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_any_req  = m0_req | m1_req;
  // On a tie the port that did not win last time is served.
  assign w_grant    = (m0_req & m1_req) ? ~r_last_grant : m1_req;
  assign w_to_hold  = ((r_state == c_ST_STROBE) || (r_state == c_ST_WAIT)) &&
                      (w_next_state == c_ST_HOLD);
  assign w_tmo_hit  = (r_state == c_ST_WAIT) && w_cnt_zero && !r_rdy_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      c_ST_IDLE: begin
        if (w_any_req) begin
          w_next_state = c_ST_SETUP;
          w_cnt_next   = c_SETUP_LD;
        end
      end
      c_ST_SETUP: begin
        if (w_cnt_zero) begin
          w_next_state = c_ST_STROBE;
          w_cnt_next   = c_STROBE_LD;
        end else begin
          w_cnt_next = r_cnt - c_ONE;
        end
      end
      c_ST_STROBE: begin
        if (w_cnt_zero && r_rdy_sync) begin
          w_next_state = c_ST_HOLD;
          w_cnt_next   = c_HOLD_LD;
        end else if (w_cnt_zero) begin
          w_next_state = c_ST_WAIT;
          w_cnt_next   = c_TMO_LD;
        end else begin
          w_cnt_next = r_cnt - c_ONE;
        end
      end
      c_ST_WAIT: begin
        if (r_rdy_sync || w_cnt_zero) begin
          w_next_state = c_ST_HOLD;
          w_cnt_next   = c_HOLD_LD;
        end else begin
          w_cnt_next = r_cnt - c_ONE;
        end
      end
      c_ST_HOLD: begin
        if (w_cnt_zero) begin
          w_next_state = c_ST_DONE;
        end else begin
          w_cnt_next = r_cnt - c_ONE;
        end
      end
      c_ST_DONE: w_next_state = c_ST_IDLE;
      default:   w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    isa_iow_n = 1'b1;
    isa_ior_n = 1'b1;
    isa_doe   = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    busy      = (r_state != c_ST_IDLE);
    case (r_state)
      c_ST_SETUP, c_ST_HOLD: isa_doe = r_write;
      c_ST_STROBE, c_ST_WAIT: begin
        isa_doe   = r_write;
        isa_iow_n = ~r_write;
        isa_ior_n = r_write;
      end
      c_ST_DONE: begin
        m0_ack = ~r_grant;
        m1_ack = r_grant;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_rdy_meta   <= 1'b1;
      r_rdy_sync   <= 1'b1;
      r_tmo_flag   <= 1'b0;
    end else begin
      r_rdy_meta <= isa_iochrdy;
      r_rdy_sync <= r_rdy_meta;
      if ((r_state == c_ST_IDLE) && w_any_req) begin
        r_grant      <= w_grant;
        r_last_grant <= w_grant;
        r_write      <= w_grant ? m1_write : m0_write;
        r_addr       <= w_grant ? m1_addr  : m0_addr;
        r_wdata      <= w_grant ? m1_wdata : m0_wdata;
      end
      if (w_to_hold && !r_write) begin
        r_rdata <= isa_din;
      end
      // Port read data only changes as the cycle completes, so it is valid with ack.
      if ((r_state == c_ST_HOLD) && w_cnt_zero && !r_write) begin
        if (r_grant) r_m1_rdata <= r_rdata;
        else         r_m0_rdata <= r_rdata;
      end
      if (w_tmo_hit)    r_tmo_flag <= 1'b1;
      else if (tmo_clr) r_tmo_flag <= 1'b0;
    end
  end

  assign isa_addr = r_addr;
  assign isa_dout = r_wdata;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;
  assign tmo_flag = r_tmo_flag;

endmodule
`default_nettype wire

// File: tb/tb_isa_io_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_isa_io_arbiter                                            |
// | Description : Scoreboard bench for the ISA I/O bus arbiter.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_isa_io_arbiter;

  localparam int SETUP_CYC  = 2;
  localparam int STROBE_CYC = 10;
  localparam int HOLD_CYC   = 2;
  localparam int TMO_CYC    = 64;
  localparam int NOM_LAT    = SETUP_CYC + STROBE_CYC + HOLD_CYC;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic [15:0] isa_addr, isa_dout, isa_din;
  logic        isa_doe, isa_iow_n, isa_ior_n, isa_iochrdy;
  logic        busy, tmo_flag, tmo_clr;

  isa_io_arbiter #(
    .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC),
    .TMO_CYC(TMO_CYC), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .isa_addr(isa_addr), .isa_dout(isa_dout), .isa_doe(isa_doe), .isa_din(isa_din),
    .isa_iow_n(isa_iow_n), .isa_ior_n(isa_ior_n), .isa_iochrdy(isa_iochrdy),
    .busy(busy), .tmo_flag(tmo_flag), .tmo_clr(tmo_clr)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] din_model(input logic [15:0] a);
    return (a == 16'h022A) ? 16'h1234 : (a ^ 16'hC3C3);
  endfunction

  // The peripheral only drives meaningful data while the read strobe is low.
  assign isa_din = !isa_ior_n ? din_model(isa_addr) : 16'hDEAD;

  typedef struct {
    int          port;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          width;
    int          lat;
    logic [15:0] rd0;
    logic [15:0] rd1;
  } exp_t;

  exp_t        sb[$];
  int          gaps[$];
  logic [15:0] exp_rd[2];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ack_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int p, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input int width, input int lat);
    exp_t e;
    if (!wr) exp_rd[p] = din_model(a);
    e.port = p; e.wr = wr; e.addr = a; e.wdata = d;
    e.width = width; e.lat = lat; e.rd0 = exp_rd[0]; e.rd1 = exp_rd[1];
    sb.push_back(e);
  endtask

  task automatic do_txn(input int p, input logic wr, input logic [15:0] a, input logic [15:0] d);
    bit got;
    got = 1'b0;
    if (p == 0) begin m0_write = wr; m0_addr = a; m0_wdata = d; m0_req = 1'b1; end
    else        begin m1_write = wr; m1_addr = a; m1_wdata = d; m1_req = 1'b1; end
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? m0_ack : m1_ack;
    end
    check("ack_received", got, 1);
    if (p == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  task automatic wait_strobe();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = !isa_iow_n || !isa_ior_n;
    end
    check("strobe_seen", seen, 1);
  endtask

  initial forever @(posedge clk) cyc++;

  // Per-transaction bus monitor; scores each completion against the scoreboard.
  initial begin
    bit          in_txn = 0, seen_stb = 0;
    int          t_start = 0, n_setup = 0, n_iow = 0, n_ior = 0, n_hold = 0;
    int          n_viol = 0, n_both = 0, idle_run = 0;
    logic [15:0] ref_addr = '0, ref_dout = '0;
    logic        ref_doe = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_txn = 0;
      end else begin
        if (!busy) idle_run++;
        if (busy && !in_txn) begin
          gaps.push_back(idle_run);
          in_txn = 1; seen_stb = 0; t_start = cyc;
          n_setup = 0; n_iow = 0; n_ior = 0; n_hold = 0; n_viol = 0; n_both = 0;
          ref_addr = isa_addr; ref_dout = isa_dout; ref_doe = isa_doe;
        end
        if (in_txn) begin
          if (!isa_iow_n) n_iow++;
          if (!isa_ior_n) n_ior++;
          if ((!isa_iow_n && !isa_ior_n) || (!isa_ior_n && isa_doe)) n_both++;
          if (!isa_iow_n || !isa_ior_n) seen_stb = 1;
          else if (!seen_stb) n_setup++;
          else if (!(m0_ack || m1_ack)) n_hold++;
          if (!(m0_ack || m1_ack) &&
              (isa_addr !== ref_addr || isa_dout !== ref_dout || isa_doe !== ref_doe))
            n_viol++;
        end
        if (m0_ack || m1_ack) begin
          ack_count++;
          idle_run = 0;
          check("ack_one_hot", m0_ack & m1_ack, 0);
          check("ack_expected", sb.size() > 0, 1);
          check("doe_in_done", isa_doe, 0);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("grant_port", m1_ack ? 1 : 0, e.port);
            check("ack_addr", isa_addr, e.addr);
            if (e.wr) check("ack_wdata", isa_dout, e.wdata);
            check("m0_rdata", m0_rdata, e.rd0);
            check("m1_rdata", m1_rdata, e.rd1);
            check("strobe_width", e.wr ? n_iow : n_ior, e.width);
            check("wrong_strobe", e.wr ? n_ior : n_iow, 0);
            check("doe_setup", ref_doe, e.wr);
            check("setup_clocks", n_setup, SETUP_CYC);
            check("hold_clocks", n_hold, HOLD_CYC);
            check("ack_latency", cyc - t_start, e.lat);
            check("bus_stability", n_viol, 0);
            check("strobe_overlap", n_both, 0);
          end
          in_txn = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; tmo_clr = 1'b0; isa_iochrdy = 1'b1;
    m0_req = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    #35;
    check("rst_iow_n", isa_iow_n, 1);
    check("rst_ior_n", isa_ior_n, 1);
    check("rst_doe", isa_doe, 0);
    check("rst_addr", isa_addr, 0);
    check("rst_dout", isa_dout, 0);
    check("rst_acks", {m0_ack, m1_ack}, 0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 0);
    check("rst_busy", busy, 0);
    check("rst_tmo", tmo_flag, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write on port 0.
    push_exp(0, 1'b1, 16'h0220, 16'h00A5, STROBE_CYC, NOM_LAT);
    do_txn(0, 1'b1, 16'h0220, 16'h00A5);
    repeat (2) @(negedge clk);

    // Single read on port 1.
    push_exp(1, 1'b0, 16'h022A, 16'h0000, STROBE_CYC, NOM_LAT);
    do_txn(1, 1'b0, 16'h022A, 16'h0000);
    repeat (5) @(negedge clk);
    check("m1_rdata_persist", m1_rdata, 16'h1234);
    check("m0_rdata_untouched", m0_rdata, 16'h0000);

    // Both ports contending for four transactions each.
    gaps.delete();
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 1'b1, 16'h0300 + 16'(i), 16'hAA00 + 16'(i), STROBE_CYC, NOM_LAT);
      push_exp(1, 1'b0, 16'h0310 + 16'(i), 16'h0000, STROBE_CYC, NOM_LAT);
    end
    fork
      for (int i = 0; i < 4; i++) do_txn(0, 1'b1, 16'h0300 + 16'(i), 16'hAA00 + 16'(i));
      for (int j = 0; j < 4; j++) do_txn(1, 1'b0, 16'h0310 + 16'(j), 16'h0000);
    join
    check("gap_count", gaps.size(), 8);
    for (int i = 1; i < gaps.size(); i++) check("idle_gap", gaps[i], 1);
    repeat (2) @(negedge clk);

    // IOCHRDY low 5 clocks past nominal strobe end, plus the synchroniser delay.
    isa_iochrdy = 1'b0;
    push_exp(0, 1'b0, 16'h0240, 16'h0000, STROBE_CYC + 5 + 2, NOM_LAT + 5 + 2);
    fork
      do_txn(0, 1'b0, 16'h0240, 16'h0000);
      begin
        wait_strobe();
        repeat (STROBE_CYC + 4) @(negedge clk);
        isa_iochrdy = 1'b1;
      end
    join
    check("tmo_after_stretch", tmo_flag, 0);
    repeat (2) @(negedge clk);

    // IOCHRDY stuck low: timeout path.
    isa_iochrdy = 1'b0;
    push_exp(0, 1'b1, 16'h0250, 16'h5555, STROBE_CYC + TMO_CYC, NOM_LAT + TMO_CYC);
    do_txn(0, 1'b1, 16'h0250, 16'h5555);
    isa_iochrdy = 1'b1;
    repeat (3) @(negedge clk);
    check("tmo_set_sticky", tmo_flag, 1);
    tmo_clr = 1'b1;
    @(negedge clk);
    tmo_clr = 1'b0;
    check("tmo_cleared", tmo_flag, 0);
    repeat (2) @(negedge clk);

    // Reset during the strobe of a write: dropped, no ack.
    m0_write = 1'b1; m0_addr = 16'h0260; m0_wdata = 16'hBEEF; m0_req = 1'b1;
    wait_strobe();
    #2 reset_n = 1'b0;
    #1;
    check("async_iow_n", isa_iow_n, 1);
    check("async_doe", isa_doe, 0);
    check("async_busy", busy, 0);
    check("async_addr", isa_addr, 0);
    m0_req = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    begin
      int acks_before;
      acks_before = ack_count;
      repeat (30) @(negedge clk);
      check("no_ack_after_reset", ack_count, acks_before);
    end

    // First contention after reset must go to port 0.
    push_exp(0, 1'b0, 16'h0270, 16'h0000, STROBE_CYC, NOM_LAT);
    push_exp(1, 1'b1, 16'h0280, 16'h1111, STROBE_CYC, NOM_LAT);
    fork
      do_txn(0, 1'b0, 16'h0270, 16'h0000);
      do_txn(1, 1'b1, 16'h0280, 16'h1111);
    join
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
